// File: rtl/store_buffer.sv
// store_buffer: write-through store FIFO with lane formatting, youngest-entry coalescing and load-conflict detection
//   clk, rst                                   clock, synchronous active-high reset
//   enq_valid/enq_ready/enq_addr/enq_data/enq_mode   committed store in, cache-side addressing
//   ld_valid/ld_addr -> ld_conflict            pending-word match for an in-flight load
//   mem_req/mem_addr/mem_wdata/mem_be/mem_ack  head entry drain to memory
//   empty, count, misalign_err                 occupancy and rejected-store pulse
module store_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enq_valid,
  output logic                        enq_ready,
  input  logic [ADDR_WIDTH-1:0]       enq_addr,
  input  logic [DATA_WIDTH-1:0]       enq_data,
  input  logic [2:0]                  enq_mode,
  input  logic                        ld_valid,
  input  logic [ADDR_WIDTH-1:0]       ld_addr,
  output logic                        ld_conflict,
  output logic                        mem_req,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  output logic [3:0]                  mem_be,
  input  logic                        mem_ack,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        misalign_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = ADDR_WIDTH - 2;
  localparam int LW = DATA_WIDTH / 4;
  localparam logic [2:0] LS_B = 3'b000, LS_H = 3'b001, LS_W = 3'b010, LS_UB = 3'b100, LS_UH = 3'b101;
  typedef enum logic {IDLE, REQ} state_t;
  state_t state_q, state_d;
  logic [WW-1:0]         addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [3:0]            be_q   [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PW-1:0]         head_q, tail_q, youngest;
  logic [CW-1:0]         count_q, count_d;
  logic                  err_q;
  logic [1:0]            off;
  logic                  is_b, is_h, is_w, fmt_ok, merge_hit, do_enq, push, pop, ld_hit;
  logic [3:0]            fmt_be;
  logic [DATA_WIDTH-1:0] fmt_data, mask, merged;
  logic                  unused_ld;
  assign unused_ld = ^ld_addr[1:0];
  always_comb begin
    off      = enq_addr[1:0];
    is_b     = enq_mode == LS_B || enq_mode == LS_UB;
    is_h     = enq_mode == LS_H || enq_mode == LS_UH;
    is_w     = enq_mode == LS_W;
    fmt_ok   = is_b || (is_h && !off[0]) || (is_w && off == 2'd0);
    fmt_be   = is_w ? 4'hF : is_h ? (off[1] ? 4'hC : 4'h3) : 4'b0001 << off;
    mask     = {{LW{fmt_be[3]}}, {LW{fmt_be[2]}}, {LW{fmt_be[1]}}, {LW{fmt_be[0]}}};
    // replicate the store onto every lane; the byte mask keeps only the addressed ones
    fmt_data = (is_w ? enq_data : is_h ? {2{enq_data[15:0]}} : {4{enq_data[7:0]}}) & mask;
    youngest = tail_q - PW'(1);
    // the head belongs to memory, so coalescing needs a second, younger entry
    merge_hit = count_q >= CW'(2) && addr_q[youngest] == enq_addr[ADDR_WIDTH-1:2];
    merged    = (data_q[youngest] & ~mask) | fmt_data;
    enq_ready = count_q < CW'(DEPTH) || merge_hit;
    do_enq    = enq_valid && enq_ready && fmt_ok;
    push      = do_enq && !merge_hit;
    pop       = state_q == REQ && mem_ack;
    count_d   = count_q + CW'(push) - CW'(pop);
    valid_d   = valid_q;
    if (pop) valid_d[head_q] = 1'b0;
    if (push) valid_d[tail_q] = 1'b1;
    state_d = state_q == IDLE ? (count_q != '0 ? REQ : IDLE) : (pop && count_d == '0 ? IDLE : REQ);
  end
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) ld_hit = ld_hit | (valid_q[i] && addr_q[i] == ld_addr[ADDR_WIDTH-1:2]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= valid_d;
      err_q   <= enq_valid && !fmt_ok;
      if (push) begin
        addr_q[tail_q] <= enq_addr[ADDR_WIDTH-1:2];
        data_q[tail_q] <= fmt_data;
        be_q[tail_q]   <= fmt_be;
        tail_q         <= tail_q + PW'(1);
      end
      if (do_enq && merge_hit) begin
        data_q[youngest] <= merged;
        be_q[youngest]   <= be_q[youngest] | fmt_be;
      end
      if (pop) head_q <= head_q + PW'(1);
    end
  end
  // the head entry is never modified while presented, so it drives memory directly
  assign mem_req      = state_q == REQ;
  assign mem_addr     = {addr_q[head_q], 2'b00};
  assign mem_wdata    = data_q[head_q];
  assign mem_be       = be_q[head_q];
  assign ld_conflict  = ld_valid && ld_hit;
  assign empty        = count_q == '0;
  assign count        = count_q;
  assign misalign_err = err_q;
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scoreboard bench for store_buffer
module tb_store_buffer;
  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, UB = 3'b100, UH = 3'b101;
  typedef struct {logic [31:0] a; logic [31:0] d; logic [3:0] be;} wr_t;
  logic clk = 0, rst = 1;
  logic enq_valid = 0, enq_ready, ld_valid = 0, ld_conflict, mem_req, mem_ack = 0, empty, misalign_err;
  logic [31:0] enq_addr = 0, enq_data = 0, ld_addr = 0, mem_addr, mem_wdata;
  logic [2:0] enq_mode = 0, count;
  logic [3:0] mem_be;
  wr_t q[$];
  int errors = 0, checks = 0;
  store_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr),
    .enq_data(enq_data), .enq_mode(enq_mode), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_conflict(ld_conflict), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .empty(empty), .count(count), .misalign_err(misalign_err));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic void fmt(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m,
                              output logic ok, output logic [3:0] be, output logic [31:0] wd);
    case (m)
      W:       begin ok = a[1:0] == 2'd0; be = 4'hF; end
      B, UB:   begin ok = 1'b1; be = 4'b0001 << a[1:0]; end
      H, UH:   begin ok = !a[0]; be = a[1] ? 4'hC : 4'h3; end
      default: begin ok = 1'b0; be = 4'h0; end
    endcase
    wd = 0;
    for (int i = 0; i < 4; i++)
      if (be[i]) wd[8*i +: 8] = m == W ? d[8*i +: 8] : (m == H || m == UH) ? d[8*(i%2) +: 8] : d[7:0];
  endfunction
  task automatic try_enq(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
    logic ok, mrg, rdy;
    logic [3:0] be;
    logic [31:0] wd, msk;
    fmt(a, d, m, ok, be, wd);
    mrg = q.size() >= 2 && q[$].a == {a[31:2], 2'b00};
    rdy = q.size() < 4 || mrg;
    enq_valid = 1; enq_addr = a; enq_data = d; enq_mode = m;
    #1;
    chk({tag, ".ready"}, enq_ready, rdy);
    step();
    enq_valid = 0;
    chk({tag, ".misalign"}, misalign_err, !ok);
    if (rdy && ok) begin
      if (mrg) begin
        for (int i = 0; i < 4; i++) msk[8*i +: 8] = {8{be[i]}};
        q[$].d = (q[$].d & ~msk) | wd;
        q[$].be = q[$].be | be;
      end else q.push_back('{{a[31:2], 2'b00}, wd, be});
    end
  endtask
  task automatic cmp_head(input string tag);
    wr_t e;
    e = q.size() > 0 ? q[0] : '{32'hx, 32'hx, 4'hx};
    chk({tag, ".addr"}, mem_addr, e.a);
    chk({tag, ".wdata"}, mem_wdata, e.d);
    chk({tag, ".be"}, mem_be, e.be);
  endtask
  task automatic drain_one(input string tag);
    int n = 0;
    while (!mem_req && n < 20) begin step(); n++; end
    if (!mem_req) begin
      errors++;
      $error("FAIL %s.timeout: observed mem_req=0 expected mem_req=1", tag);
    end else begin
      cmp_head(tag);
      mem_ack = 1;
      step();
      mem_ack = 0;
      void'(q.pop_front());
    end
  endtask
  initial begin
    step(); step();
    rst = 0;
    chk("rst.empty", empty, 1); chk("rst.count", count, 0);
    chk("rst.req", mem_req, 0); chk("rst.err", misalign_err, 0);
    mem_ack = 1; step(); mem_ack = 0;
    chk("idle_ack.count", count, 0); chk("idle_ack.req", mem_req, 0);
    try_enq("sw1", 32'h100, 32'hDEADBEEF, W);
    chk("sw1.lat0", mem_req, 0); chk("sw1.count", count, 1);
    step();
    chk("sw1.lat1", mem_req, 1);
    drain_one("sw1");
    chk("sw1.empty", empty, 1); chk("sw1.req_off", mem_req, 0);
    try_enq("sb1", 32'h203, 32'h11, B);
    try_enq("sb2", 32'h200, 32'h22, UB);
    try_enq("sh3", 32'h202, 32'h3344, H);
    chk("merge.count", count, 2);
    drain_one("merge.e0"); drain_one("merge.e1");
    chk("merge.empty", empty, 1);
    for (int i = 0; i < 4; i++) try_enq("fill", 32'h400 + 32'(4*i), 32'hA000 + 32'(i), W);
    chk("full.count", count, 4);
    try_enq("stall", 32'h410, 32'hA004, W);
    chk("stall.count", count, 4);
    chk("stall.req", mem_req, 1);
    cmp_head("full_ack");
    mem_ack = 1;
    try_enq("full_ack", 32'h410, 32'hA004, W);
    mem_ack = 0;
    void'(q.pop_front());
    chk("full_ack.count", count, 3);
    try_enq("refill", 32'h410, 32'hA004, W);
    chk("refill.count", count, 4);
    for (int i = 0; i < 4; i++) drain_one("order");
    chk("order.empty", empty, 1);
    try_enq("ld_sw", 32'h300, 32'h12345678, W);
    ld_valid = 1; ld_addr = 32'h302; #1;
    chk("ld.hit", ld_conflict, 1);
    ld_addr = 32'h304; #1;
    chk("ld.miss", ld_conflict, 0);
    drain_one("ld_sw");
    ld_addr = 32'h302; #1;
    chk("ld.drained", ld_conflict, 0);
    ld_valid = 0; #1;
    chk("ld.novalid", ld_conflict, 0);
    try_enq("sh_mis", 32'h101, 32'h5555, H);
    chk("sh_mis.count", count, 0);
    step();
    chk("sh_mis.pulse_end", misalign_err, 0);
    try_enq("sw_mis", 32'h102, 32'h1, W);
    try_enq("bad_mode", 32'h100, 32'h1, 3'b011);
    chk("bad_mode.count", count, 0);
    try_enq("uh_hi", 32'h602, 32'hBEEF, UH);
    drain_one("uh_hi");
    for (int i = 0; i < 3; i++) try_enq("rst_fill", 32'h500 + 32'(4*i), 32'h77 + 32'(i), W);
    chk("rst_fill.req", mem_req, 1);
    rst = 1; step(); rst = 0;
    q.delete();
    chk("midrst.req", mem_req, 0); chk("midrst.count", count, 0); chk("midrst.empty", empty, 1);
    ld_valid = 1; ld_addr = 32'h500; #1;
    chk("midrst.ld", ld_conflict, 0);
    ld_valid = 0;
    try_enq("post_rst", 32'h700, 32'hCAFEF00D, W);
    drain_one("post_rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-through store buffer between the data cache and data memory.
- Accepts committed stores with cache-side addressing (address plus LS_mode), converts each into a word-aligned write with a byte-enable mask, and queues it in a DEPTH-entry FIFO.
- Drains entries to memory over a req/ack handshake, coalescing back-to-back stores to the same word.
- Flags loads whose word is still pending so the core can stall them.

Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, store data width (fixed 4 byte lanes)
- DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- enq_valid  in  1  store presented
- enq_ready  out  1  buffer can accept/merge this cycle
- enq_addr  in  ADDR_WIDTH  store byte address
- enq_data  in  DATA_WIDTH  store data, right-aligned as from the register file
- enq_mode  in  3  LS_mode (shared B/H/W/UB/UH defines)
- ld_valid  in  1  load in flight
- ld_addr  in  ADDR_WIDTH  load byte address
- ld_conflict  out  1  load word matches a pending entry
- mem_req  out  1  head entry presented to memory
- mem_addr  out  ADDR_WIDTH  head word address, bits[1:0]=0
- mem_wdata  out  DATA_WIDTH  head lane-aligned data
- mem_be  out  4  head byte enables
- mem_ack  in  1  memory accepted head this cycle
- empty  out  1  count==0
- count  out  $clog2(DEPTH)+1  valid entries
- misalign_err  out  1  one-cycle pulse on rejected misaligned store

Behaviour:
- Reset: count=0, head/tail pointers=0, all valid bits cleared, mem_req=0, misalign_err=0, empty=1. Reset mid-handshake discards all entries; mem_req drops the next cycle.
- Lane formatting, off = enq_addr[1:0]:
  - W: be=1111, data=enq_data; requires off=0.
  - B/UB: be=1<<off; enq_data[7:0] placed on lane off.
  - H/UH: off 0 gives be=0011, data[15:0] on lanes 1:0; off 2 gives be=1100, lanes 3:2.
  - Any other offset for H/W, or an unrecognised mode: store dropped, misalign_err pulses 1 cycle, no state change.
- merge_hit: count>=2, enq word address == youngest entry word address. The head is never merged into because it is owned by memory.
- enq_ready = (count<DEPTH) || merge_hit. Evaluated on the start-of-cycle count; a pop in the same cycle does not free a slot for that cycle's enqueue.
- Enqueue (enq_valid && enq_ready, formatting legal):
  - merge_hit: youngest.be |= be, and the youngest entry's data lanes with be=1 are overwritten. count unchanged.
  - Otherwise: write to tail, tail++ (wraps mod DEPTH), count++.
- Drain FSM:
  - States: IDLE (mem_req=0), REQ (mem_req=1).
  - IDLE -> REQ when count>0 at the clock edge. mem_* outputs are registered from the head and become valid with mem_req.
  - In REQ, mem_addr/wdata/be are held stable until ack.
  - mem_ack in REQ pops the head (head++, count--). If the remaining count>0, stay in REQ and present the new head next cycle; else go to IDLE.
  - mem_ack while mem_req=0 is ignored.
- Simultaneous enqueue and pop in one cycle: count unchanged; both pointers advance.
- ld_conflict is combinational: ld_valid && any valid entry with word addr == ld_addr[ADDR_WIDTH-1:2]. Byte masks are ignored; there is no forwarding.
- Latency: store enqueued at edge N, empty buffer → mem_req=1 after edge N+1. Minimum 1 cycle per entry drained with continuous ack.
- Ordering: memory sees writes in enqueue order. Merging only into the youngest entry preserves order.

Test Plan:
- Reset, then SW 0xDEADBEEF @0x100 → mem_req 1 cycle later, mem_addr=0x100, be=1111, wdata=0xDEADBEEF; ack → empty=1, mem_req=0 next cycle.
- With ack held low: SB 0x11 @0x203, SB 0x22 @0x200, then SH 0x3344 @0x202.
  - Required: entry0 be=1000 data=0x11000000.
  - Entry1 holds the merge of the second and third stores: be=1101, data=0x33440022, count=2.
- Five SW with ack low, DEPTH=4 → enq_ready=0 after 4th, 5th stalled; single ack → 5th accepted next cycle; memory receives all 5 in order.
- Buffer full, ack and enq_valid in same cycle → enq not accepted that cycle; accepted the following cycle; count sequence 4,3,4.
- SW pending @0x300, ld_valid @0x302 → ld_conflict=1; after drain ld_conflict=0; ld @0x304 → 0 throughout.
- SH @0x101 → misalign_err pulse, count stays 0. Assert rst during REQ with 3 entries → next cycle mem_req=0, count=0, empty=1.
